uart_tx: RTL and testbench

- UART transmitter paired with the team's UART receiver.
- Bytes are written into an internal 16x8 FIFO. A framing state machine pops them and serialises each as: start bit, 8 data bits LSB-first, optional parity bit, 1 or 2 stop bits.
- Baud divisor, parity select and stop select use the same encoding as the receiver, so a loopback txd->rxd works with identical settings.
- The FIFO is implemented inside this module; no vendor FIFO IP.

---
 rtl/uart_tx.sv | 118 +++++++++++
 tb/tb_uart_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with an internal byte FIFO and a start/data/parity/stop framing FSM.
// Ports:
//   mclk, reset        clock; asynchronous active-low reset
//   baudrate           bit period minus one, in mclk cycles (latched per frame)
//   parity_sel         00 none, 01 even, 10 odd, 11 none (latched per frame)
//   stop_sel           0 one stop bit, 1 two stop bits (latched per frame)
//   wen, wdata         FIFO write strobe and byte
//   full, overrun      FIFO full; one-cycle pulse on a write while full
//   fifo_cnt           bytes queued
//   busy, tx_done      FSM active or FIFO non-empty; one-cycle pulse in DONE
//   txd                registered serial line, idles high
//   debug_state        current FSM state
module uart_tx #(
    parameter int FIFO_AW = 4
) (
    input  logic               mclk,
    input  logic               reset,
    input  logic [15:0]        baudrate,
    input  logic [1:0]         parity_sel,
    input  logic               stop_sel,
    input  logic               wen,
    input  logic [7:0]         wdata,
    output logic               full,
    output logic               overrun,
    output logic [FIFO_AW:0]   fifo_cnt,
    output logic               busy,
    output logic               tx_done,
    output logic               txd,
    output logic [1:0]         debug_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nx;
    logic [7:0] mem [0:(1<<FIFO_AW)-1];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic push, pop, empty;
    logic [15:0] cnt1, br_l;
    logic [3:0] cnt2, nidx, last;
    logic [2:0] didx;
    logic [7:0] sh;
    logic par_en, par_bit, stop_l, bit_end, nbit;

    // count never exceeds the depth, so its MSB alone means full
    assign full = fifo_cnt[FIFO_AW];
    assign empty = fifo_cnt == '0;
    assign push = wen && !full;
    assign pop = state == IDLE && !empty;
    assign debug_state = state;
    assign bit_end = cnt1 == br_l;
    assign nidx = cnt2 + 4'd1;
    assign didx = nidx[2:0] - 3'd1;
    assign last = 4'd9 + {3'b0, par_en} + {3'b0, stop_l};
    // indices past the last stop bit also yield 1, so the line stays high into DONE
    assign nbit = nidx <= 4'd8 ? sh[didx] : (nidx == 4'd9 && par_en) ? par_bit : 1'b1;

    always_ff @(posedge mclk)
        if (push) mem[wptr] <= wdata;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            fifo_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            overrun <= wen && full;
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        tx_done = 1'b0;
        busy = 1'b0;
        state_nx = state == IDLE ? (empty ? IDLE : SEND) :
                   state == SEND ? ((bit_end && cnt2 == last) ? DONE : SEND) : IDLE;
        tx_done = state == DONE;
        busy = state != IDLE || !empty;
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            txd <= 1'b1;
            cnt1 <= '0;
            cnt2 <= '0;
            sh <= '0;
            br_l <= '0;
            par_en <= 1'b0;
            par_bit <= 1'b0;
            stop_l <= 1'b0;
        end else if (pop) begin
            sh <= mem[rptr];
            br_l <= baudrate;
            par_en <= parity_sel[0] ^ parity_sel[1];
            par_bit <= parity_sel[1] ? ~^mem[rptr] : ^mem[rptr];
            stop_l <= stop_sel;
            cnt1 <= '0;
            cnt2 <= '0;
            txd <= 1'b0;
        end else if (state == SEND) begin
            if (bit_end) begin
                cnt1 <= '0;
                cnt2 <= nidx;
                txd <= nbit;
            end else begin
                cnt1 <= cnt1 + 16'd1;
            end
        end else begin
            txd <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
module tb_uart_tx;
    logic        mclk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] baudrate = 16'd3;
    logic [1:0]  parity_sel = 2'b00;
    logic        stop_sel = 1'b0;
    logic        wen = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        full, overrun, busy, tx_done, txd;
    logic [4:0]  fifo_cnt;
    logic [1:0]  debug_state;
    int checks = 0;
    int failures = 0;
    int w;

    uart_tx #(.FIFO_AW(4)) dut (
        .mclk(mclk), .reset(reset), .baudrate(baudrate), .parity_sel(parity_sel),
        .stop_sel(stop_sel), .wen(wen), .wdata(wdata), .full(full), .overrun(overrun),
        .fifo_cnt(fifo_cnt), .busy(busy), .tx_done(tx_done), .txd(txd),
        .debug_state(debug_state)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wen = 1'b1;
        wdata = b;
        @(negedge mclk);
        wen = 1'b0;
    endtask

    // Waits for a start bit, samples every bit mid-period, and checks the DONE pulse
    // lands exactly N*(br+1) cycles after the start bit began. pbit<0 means no parity.
    task automatic frame(input string tag, input logic [7:0] exp, input int br,
                         input int pbit, input bit two, output int wait_cycles);
        int c;
        int n;
        int t;
        logic [7:0] d;
        logic eb;
        wait_cycles = 0;
        d = 8'h00;
        while (txd !== 1'b0 && wait_cycles < 20000) begin
            @(negedge mclk);
            wait_cycles++;
        end
        chk({tag, "_start"}, {31'd0, txd}, 32'd0);
        if (txd !== 1'b0) return;
        n = 10 + (pbit >= 0 ? 1 : 0) + (two ? 1 : 0);
        c = 0;
        for (int k = 0; k < n; k++) begin
            t = k * (br + 1) + br / 2;
            while (c < t) begin
                @(negedge mclk);
                c++;
            end
            if (k >= 1 && k <= 8) begin
                d[k-1] = txd;
            end else begin
                eb = (k == 0) ? 1'b0 : (k == 9 && pbit >= 0) ? pbit[0] : 1'b1;
                chk($sformatf("%s_bit%0d", tag, k), {31'd0, txd}, {31'd0, eb});
            end
        end
        chk({tag, "_data"}, {24'd0, d}, {24'd0, exp});
        while (c < n * (br + 1) - 1) begin
            @(negedge mclk);
            c++;
        end
        chk({tag, "_done_early"}, {31'd0, tx_done}, 32'd0);
        @(negedge mclk);
        chk({tag, "_done"}, {31'd0, tx_done}, 32'd1);
        chk({tag, "_done_state"}, {30'd0, debug_state}, 32'd2);
        chk({tag, "_done_txd"}, {31'd0, txd}, 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge mclk);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {27'd0, fifo_cnt}, 32'd0);
        chk("rst_state", {30'd0, debug_state}, 32'd0);
        reset = 1'b1;
        @(negedge mclk);

        // basic frame 0x55, 4 clocks per bit
        push(8'h55);
        chk("basic_idle_after_push", {31'd0, txd}, 32'd1);
        chk("basic_busy", {31'd0, busy}, 32'd1);
        frame("basic", 8'h55, 3, -1, 1'b0, w);
        chk("basic_latency", w, 32'd1);
        chk("basic_busy_done", {31'd0, busy}, 32'd1);
        @(negedge mclk);
        chk("basic_busy_drop", {31'd0, busy}, 32'd0);
        chk("basic_done_drop", {31'd0, tx_done}, 32'd0);
        chk("basic_idle", {30'd0, debug_state}, 32'd0);

        // parity on 0x07 (three ones): even bit 1, odd bit 0
        baudrate = 16'd1;
        parity_sel = 2'b01;
        push(8'h07);
        frame("even", 8'h07, 1, 1, 1'b0, w);
        parity_sel = 2'b10;
        push(8'h07);
        frame("odd", 8'h07, 1, 0, 1'b0, w);

        // two stop bits, even parity on 0xA3 (four ones) -> parity bit 0
        parity_sel = 2'b01;
        stop_sel = 1'b1;
        push(8'hA3);
        frame("stop2", 8'hA3, 1, 0, 1'b1, w);

        // back-to-back frames with a 2-cycle gap
        parity_sel = 2'b00;
        stop_sel = 1'b0;
        baudrate = 16'd2;
        push(8'h12);
        push(8'h34);
        frame("b2b0", 8'h12, 2, -1, 1'b0, w);
        frame("b2b1", 8'h34, 2, -1, 1'b0, w);
        chk("b2b_gap", w, 32'd2);
        @(negedge mclk);

        // overrun: 18 writes, first popped at once, 16 queued, 18th dropped;
        // the divisor change mid-frame applies only from the next pop
        baudrate = 16'd1000;
        fork
            frame("ovr0", 8'h00, 1000, -1, 1'b0, w);
            begin
                wen = 1'b1;
                for (int i = 0; i < 18; i++) begin
                    wdata = 8'(i);
                    @(negedge mclk);
                    if (i == 16) begin
                        chk("ovr_full16", {31'd0, full}, 32'd1);
                        chk("ovr_nopulse", {31'd0, overrun}, 32'd0);
                    end
                end
                wen = 1'b0;
                chk("ovr_pulse", {31'd0, overrun}, 32'd1);
                chk("ovr_full", {31'd0, full}, 32'd1);
                chk("ovr_cnt", {27'd0, fifo_cnt}, 32'd16);
                @(negedge mclk);
                chk("ovr_pulse_end", {31'd0, overrun}, 32'd0);
                baudrate = 16'd1;
            end
        join
        for (int i = 1; i <= 16; i++) begin
            frame($sformatf("ovr%0d", i), 8'(i), 1, -1, 1'b0, w);
            chk($sformatf("ovr%0d_gap", i), w, 32'd2);
        end
        @(negedge mclk);
        chk("ovr_drained_cnt", {27'd0, fifo_cnt}, 32'd0);
        chk("ovr_drained_busy", {31'd0, busy}, 32'd0);

        // reset during data bit 4 (0xEF has bit4 = 0)
        baudrate = 16'd3;
        push(8'hEF);
        push(8'h11);
        push(8'h22);
        repeat (20) @(negedge mclk);
        chk("mid_bit4_low", {31'd0, txd}, 32'd0);
        chk("mid_cnt", {27'd0, fifo_cnt}, 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_txd", {31'd0, txd}, 32'd1);
        chk("mid_rst_cnt", {27'd0, fifo_cnt}, 32'd0);
        chk("mid_rst_state", {30'd0, debug_state}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge mclk);
        reset = 1'b1;
        @(negedge mclk);
        chk("post_rst_idle", {31'd0, txd}, 32'd1);
        push(8'h3C);
        frame("post", 8'h3C, 3, -1, 1'b0, w);
        chk("post_latency", w, 32'd1);
        @(negedge mclk);
        chk("post_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
